axis_burst_serializer: RTL and testbench

//  Downstream consumer of the peak detector's burst stream. Accepts tlast-framed

---
 rtl/axis_burst_serializer_pkg.sv | 14 +
 rtl/axis_burst_serializer.sv | 125 ++++++++++++
 tb/tb_axis_burst_serializer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_burst_serializer_pkg.sv
// axis_burst_serializer_pkg: packet field layout, sync bytes, FSM states and width helper
package axis_burst_serializer_pkg;
   localparam logic [7:0] SYNC_HDR_DEF = 8'hA5;
   localparam logic [7:0] SYNC_TRL_DEF = 8'h5A;
   localparam int SYNC_LSB  = 24;
   localparam int SEQ_LSB   = 16;
   localparam int SHORT_BIT = 15;
   localparam int LONG_BIT  = 14;
   localparam int CNT_W     = 14;
   typedef enum logic [2:0] {IDLE, HEADER, DATA, DATA_WAIT, TRAILER} state_t;
   function automatic int slice_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/axis_burst_serializer.sv
// axis_burst_serializer: frames tlast bursts of wide beats into HEADER/DATA/TRAILER narrow packets
module axis_burst_serializer
   import axis_burst_serializer_pkg::*;
#(
   parameter int NUM_CHANNELS  = 4,
   parameter int CHANNEL_WIDTH = 64,
   parameter int BURST_LENGTH  = 32,
   parameter int OUT_WIDTH     = 32,
   parameter logic [7:0] SYNC_HDR = SYNC_HDR_DEF,
   parameter logic [7:0] SYNC_TRL = SYNC_TRL_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  s_axis_tvalid,
   output logic                                  s_axis_tready,
   input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
   input  logic                                  s_axis_tlast,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready,
   output logic [OUT_WIDTH-1:0]                  m_axis_tdata,
   output logic                                  m_axis_tlast
);
   localparam int DATA_WIDTH = NUM_CHANNELS * CHANNEL_WIDTH;
   localparam int NUM_SLICES = DATA_WIDTH / OUT_WIDTH;
   localparam int SW = slice_w(NUM_SLICES);
   localparam logic [SW-1:0] LAST_SLICE = SW'(NUM_SLICES - 1);
   state_t state, state_n;
   logic [DATA_WIDTH-1:0] beat_reg;
   logic beat_end, short_err, long_err, alive;
   logic [CNT_W-1:0] beat_cnt, cnt_inc;
   logic [SW-1:0] slice;
   logic [7:0] seq;
   logic load, take, hit, nv, nl;
   logic [OUT_WIDTH-1:0] nd, hdr_word, trl_word, slice_word;
   assign load = !m_axis_tvalid | m_axis_tready;
   assign take = s_axis_tvalid & s_axis_tready;
   assign cnt_inc = beat_cnt + 1'b1;
   assign hit = cnt_inc == CNT_W'(BURST_LENGTH);
   assign hdr_word = OUT_WIDTH'({SYNC_HDR, seq, 16'(BURST_LENGTH)});
   assign trl_word = OUT_WIDTH'({SYNC_TRL, seq, short_err, long_err, beat_cnt});
   assign slice_word = beat_reg[OUT_WIDTH*int'(slice) +: OUT_WIDTH];
   // State register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   // Next state, input ready (never from s_axis_tvalid) and the word offered to the output register
   always_comb begin
      state_n = state;
      s_axis_tready = 1'b0;
      nv = 1'b0;
      nd = '0;
      nl = 1'b0;
      case (state)
         IDLE: begin
            s_axis_tready = alive;
            nv = take;
            nd = take ? hdr_word : '0;
            if (take) state_n = load ? DATA : HEADER;
         end
         HEADER: begin
            nv = 1'b1;
            nd = hdr_word;
            if (load) state_n = DATA;
         end
         DATA: begin
            nv = 1'b1;
            nd = slice_word;
            if (load && slice == LAST_SLICE) begin
               if (beat_end) state_n = TRAILER;
               else begin
                  s_axis_tready = 1'b1;
                  state_n = s_axis_tvalid ? DATA : DATA_WAIT;
               end
            end
         end
         DATA_WAIT: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) state_n = DATA;
         end
         TRAILER: begin
            nv = 1'b1;
            nd = trl_word;
            nl = 1'b1;
            if (load) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // Beat capture, frame-length bookkeeping, sequence number and registered output word
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         alive <= 1'b0;
         beat_reg <= '0;
         beat_end <= 1'b0;
         beat_cnt <= '0;
         slice <= '0;
         seq <= '0;
         short_err <= 1'b0;
         long_err <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tlast <= 1'b0;
      end else begin
         alive <= 1'b1;
         if (take) begin
            beat_reg <= s_axis_tdata;
            beat_end <= s_axis_tlast | hit;
            beat_cnt <= cnt_inc;
            short_err <= s_axis_tlast & !hit;
            long_err <= !s_axis_tlast & hit;
            slice <= '0;
         end else if (state == DATA && load) slice <= slice == LAST_SLICE ? '0 : slice + 1'b1;
         else if (state == TRAILER && load) begin
            seq <= seq + 1'b1;
            beat_cnt <= '0;
            short_err <= 1'b0;
            long_err <= 1'b0;
         end
         if (load) begin
            m_axis_tvalid <= nv;
            m_axis_tdata <= nd;
            m_axis_tlast <= nl;
         end
      end
endmodule

// File: tb/tb_axis_burst_serializer.sv
// tb_axis_burst_serializer: randomized bursts checked against a packet-level reference model
module tb_axis_burst_serializer;
   localparam int BL = 32;
   localparam int OW = 32;
   localparam int DW = 256;
   localparam int NS = DW / OW;
   logic clk = 1'b0, rst = 1'b1;
   logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic m_tvalid, m_tready = 1'b1, m_tlast;
   logic [OW-1:0] m_tdata;
   int errors = 0, checks = 0;
   logic [OW:0] got[$], exp_q[$];
   bit rnd_ready = 0, abort = 0;
   int gap_max = 0;
   int m_seq = 0, m_cnt = 0;
   bit m_open = 0;

   axis_burst_serializer dut (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      m_tready = rnd_ready ? 1'($urandom % 2) : 1'b1;
   end

   initial begin
      logic stall;
      logic [OW:0] held;
      stall = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst) stall = 0;
         else begin
            if (stall) begin
               checks++;
               if ({m_tlast, m_tdata} !== held || m_tvalid !== 1'b1) begin
                  errors++;
                  $display("FAIL hold_stable: got v=%b %h, required v=1 %h", m_tvalid, {m_tlast, m_tdata}, held);
               end
            end
            if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
            stall = m_tvalid && !m_tready;
            held = {m_tlast, m_tdata};
         end
      end
   end

   task automatic model_reset();
      m_seq = 0;
      m_cnt = 0;
      m_open = 0;
      exp_q.delete();
   endtask

   task automatic model_beat(input logic [DW-1:0] d, input bit last);
      if (!m_open) begin
         exp_q.push_back({1'b0, 8'hA5, 8'(m_seq), 16'(BL)});
         m_open = 1;
         m_cnt = 0;
      end
      m_cnt++;
      for (int i = 0; i < NS; i++) exp_q.push_back({1'b0, d[i*OW +: OW]});
      if (last || m_cnt == BL) begin
         exp_q.push_back({1'b1, 8'h5A, 8'(m_seq), 1'(last && m_cnt < BL), 1'(!last && m_cnt == BL), 14'(m_cnt)});
         m_seq = (m_seq + 1) % 256;
         m_open = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      abort = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      model_reset();
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input bit last);
      int t;
      bit ok;
      repeat ($urandom_range(0, gap_max)) begin
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b1;
      s_tdata = d;
      s_tlast = last;
      t = 0;
      ok = 0;
      forever begin
         @(negedge clk);
         if (abort) break;
         if (s_tready) begin
            ok = 1;
            break;
         end
         if (++t > 2000) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: got no s_axis_tready in 2000 cycles, required acceptance");
            abort = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      if (ok && !abort) model_beat(d, last);
   endtask

   task automatic send_burst(input int n, input int last_at);
      logic [DW-1:0] d;
      for (int i = 1; i <= n; i++) begin
         if (abort) break;
         for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
         send_beat(d, i == last_at);
      end
   endtask

   task automatic drain_compare(input string name);
      int t;
      t = 0;
      while (got.size() < exp_q.size() && t < exp_q.size() * 6 + 200) begin
         @(posedge clk);
         t++;
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_len: got %0d words, required %0d", name, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_word%0d: got %h, required %h", name, i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic check_word(input string name, input int idx, input logic [OW:0] req);
      logic [OW:0] w;
      w = got.size() > idx ? got[idx] : 'x;
      checks++;
      if (w !== req) begin
         errors++;
         $display("FAIL %s: word %0d got %h, required %h", name, idx, w, req);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({m_tvalid, m_tdata, m_tlast, s_tready} !== '0) begin
         errors++;
         $display("FAIL %s: got v=%b d=%h l=%b rdy=%b, required all 0", name, m_tvalid, m_tdata, m_tlast, s_tready);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      check_idle_outputs("reset_outputs");
   endtask

   task automatic test_nominal();
      do_reset();
      send_burst(32, 32);
      send_burst(1, 1);
      drain_compare("nominal");
      check_word("nominal_header", 0, {1'b0, 32'hA5000020});
      check_word("nominal_trailer", 257, {1'b1, 32'h5A000020});
      check_word("nominal_next_header", 258, {1'b0, 32'hA5010020});
   endtask

   task automatic test_short();
      do_reset();
      send_burst(5, 5);
      drain_compare("short");
      check_word("short_trailer", 41, {1'b1, 32'h5A008005});
   endtask

   task automatic test_long();
      do_reset();
      send_burst(40, 0);
      drain_compare("long");
      check_word("long_trailer", 257, {1'b1, 32'h5A004020});
      check_word("long_next_header", 258, {1'b0, 32'hA5010020});
   endtask

   task automatic test_backpressure();
      do_reset();
      rnd_ready = 1;
      gap_max = 3;
      send_burst(32, 32);
      drain_compare("backpressure");
      check_word("bp_header", 0, {1'b0, 32'hA5000020});
      rnd_ready = 0;
      gap_max = 0;
   endtask

   task automatic test_back_to_back();
      int n, lasts;
      do_reset();
      for (int p = 0; p < 257; p++) begin
         n = $urandom_range(1, 3);
         send_burst(n, n);
      end
      drain_compare("b2b");
      lasts = 0;
      foreach (got[i]) if (got[i][OW]) lasts++;
      checks++;
      if (lasts != 257) begin
         errors++;
         $display("FAIL b2b_trailers: got %0d, required 257", lasts);
      end
      check_word("b2b_wrapped_trailer_seq", got.size() - 1, {1'b1, 8'h5A, 8'h00, got.size() > 0 ? got[got.size()-1][15:0] : 16'h0});
   endtask

   task automatic test_reset_mid();
      int t;
      do_reset();
      fork
         send_burst(32, 32);
         begin
            t = 0;
            while (got.size() < 1 + 9 * NS + 3 && t < 2000) begin
               @(posedge clk);
               t++;
            end
            if (t >= 2000) begin
               checks++;
               errors++;
               $display("FAIL midreset_reach: got %0d words, required %0d", got.size(), 1 + 9 * NS + 3);
            end
            @(posedge clk);
            #1;
            rst = 1'b1;
            abort = 1;
         end
      join
      #1;
      check_idle_outputs("midreset_outputs");
      do_reset();
      send_burst(32, 32);
      drain_compare("after_reset");
      check_word("after_reset_header", 0, {1'b0, 32'hA5000020});
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_short();
      test_long();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
